event_arbiter: RTL and testbench

//  Collects toggle-style debounced button/sensor signals (test, medicina, energia, ultrasonido,

---
 rtl/event_pkg.sv | 40 ++++
 rtl/toggle_edge_det.sv | 27 ++
 rtl/event_arbiter.sv | 149 ++++++++++++++
 tb/tb_event_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// event_pkg: shared event codes, arbiter state encoding and priority helpers
// for the event_arbiter slice.
package event_pkg;

    // Number of toggle sources feeding the arbiter.
    localparam int NUM_SRC = 5;

    // Event codes presented on ev_code.
    localparam logic [2:0] EV_NONE     = 3'd0;
    localparam logic [2:0] EV_TEST     = 3'd1;
    localparam logic [2:0] EV_MEDICINA = 3'd2;
    localparam logic [2:0] EV_ENERGIA  = 3'd3;
    localparam logic [2:0] EV_ULT      = 3'd4;
    localparam logic [2:0] EV_FOT      = 3'd5;

    // Arbiter states: waiting for work, offering an event, resting after a grant.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_COOLDOWN = 2'd2
    } arb_state_t;

    // Bit 0 (test) has the highest priority, so the winner is the lowest set bit.
    function automatic logic [NUM_SRC-1:0] grant_mask(input logic [NUM_SRC-1:0] p);
        return p & (~p + NUM_SRC'(1));
    endfunction

    // Event code of the highest-priority pending source, EV_NONE if nothing pending.
    function automatic logic [2:0] highest_code(input logic [NUM_SRC-1:0] p);
        logic [2:0] code;
        code = EV_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (p[i]) begin
                code = 3'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/toggle_edge_det.sv
// toggle_edge_det: turns a toggle-style level input into a one-cycle registered
// pulse on either edge. The first clock after reset only captures the input so
// a line already sitting high at release does not look like a toggle.
module toggle_edge_det (
    input  logic clk,
    input  logic reset_tmp,
    input  logic din,
    output logic pulse
);

    logic prev_q;
    logic armed;

    // Track the previous level, arm after the first sample, and flag any change.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            prev_q <= 1'b0;
            armed  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            prev_q <= din;
            armed  <= 1'b1;
            pulse  <= armed & (din ^ prev_q);
        end
    end

endmodule

// File: rtl/event_arbiter.sv
// event_arbiter: converts toggles from the five debounced sources into events,
// keeps one pending flag per source, and hands events to the pet FSM one at a
// time over valid/ready in fixed priority (test > medicina > energia > ult > fot),
// resting COOLDOWN cycles after each accepted event.
// Optional feature macro: DROP_CNT_EN enables the saturating merged-event counter;
// without it drop_cnt is tied to zero.
module event_arbiter
    import event_pkg::*;
#(
    parameter int COOLDOWN = 4,
    parameter int DROP_W   = 8
) (
    input  logic                clk,
    input  logic                reset_tmp,
    input  logic                s_test,
    input  logic                s_medicina,
    input  logic                s_energia,
    input  logic                s_ult,
    input  logic                s_fot,
    input  logic                ev_ready,
    output logic                ev_valid,
    output logic [2:0]          ev_code,
    output logic [NUM_SRC-1:0]  pending,
    output logic [DROP_W-1:0]   drop_cnt
);

    // Cooldown counter is at least one bit wide even when cooldown is disabled.
    localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] pulse;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] pending_d;
    arb_state_t         state_q;
    arb_state_t         state_d;
    logic               valid_d;
    logic [2:0]         code_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    assign src = {s_fot, s_ult, s_energia, s_medicina, s_test};

    // One edge detector per source; bit order matches the pending vector.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_det
        toggle_edge_det u_det (
            .clk       (clk),
            .reset_tmp (reset_tmp),
            .din       (src[g]),
            .pulse     (pulse[g])
        );
    end

    // Next-state, offer and pending logic; a fresh toggle beats a same-cycle grant clear.
    always_comb begin
        state_d = state_q;
        valid_d = ev_valid;
        code_d  = ev_code;
        cnt_d   = cnt_q;
        grant   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending != '0) begin
                    grant   = grant_mask(pending);
                    code_d  = highest_code(pending);
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (ev_ready) begin
                    valid_d = 1'b0;
                    code_d  = EV_NONE;
                    if (COOLDOWN > 0) begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                code_d  = EV_NONE;
            end
        endcase
        pending_d = (pending & ~grant) | pulse;
    end

    // State, offer, cooldown counter and pending flags; reset drops any offer in flight.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            state_q  <= ST_IDLE;
            ev_valid <= 1'b0;
            ev_code  <= EV_NONE;
            cnt_q    <= '0;
            pending  <= '0;
        end else begin
            state_q  <= state_d;
            ev_valid <= valid_d;
            ev_code  <= code_d;
            cnt_q    <= cnt_d;
            pending  <= pending_d;
        end
    end

`ifdef DROP_CNT_EN
    localparam int SUM_W = DROP_W + 3;

    logic [NUM_SRC-1:0] merged;
    logic [2:0]         merge_count;
    logic [SUM_W-1:0]   drop_sum;
    logic [DROP_W-1:0]  drop_q;

    // A toggle on a source whose flag is still up and not being granted is lost; count them.
    always_comb begin
        merged      = pulse & pending & ~grant;
        merge_count = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            merge_count = merge_count + 3'(merged[i]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(merge_count);
    end

    // Saturating lost-event counter, cleared only by reset.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            drop_q <= '0;
        end else if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
            drop_q <= '1;
        end else begin
            drop_q <= drop_sum[DROP_W-1:0];
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_event_arbiter.sv
// tb_event_arbiter: directed scenarios plus a randomized phase, every cycle
// compared against a behavioural model of the arbiter's rules.
module tb_event_arbiter;

    localparam int COOLDOWN = 4;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset_tmp;
    logic [4:0]        ins;
    logic              ev_ready;
    logic              ev_valid;
    logic [2:0]        ev_code;
    logic [4:0]        pending;
    logic [DROP_W-1:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    event_arbiter #(.COOLDOWN(COOLDOWN), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .reset_tmp  (reset_tmp),
        .s_test     (ins[0]),
        .s_medicina (ins[1]),
        .s_energia  (ins[2]),
        .s_ult      (ins[3]),
        .s_fot      (ins[4]),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .pending    (pending),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: flags, an offer slot, and the earliest cycle a new grant may occur.
    int         cyc;
    int         m_free_at;
    int         m_drop;
    int         m_pick;
    logic       m_valid;
    logic       m_armed;
    logic [2:0] m_code;
    logic [4:0] m_pending;
    logic [4:0] m_det;
    logic [4:0] m_last;
    logic [4:0] m_clr;
    logic [DROP_W-1:0] exp_drop;

`ifdef DROP_CNT_EN
    assign exp_drop = DROP_W'(m_drop);
`else
    assign exp_drop = '0;
`endif

    always @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            cyc = 0; m_free_at = 0; m_drop = 0;
            m_valid = 1'b0; m_armed = 1'b0; m_code = 3'd0;
            m_pending = '0; m_det = '0; m_last = '0;
        end else begin
            cyc   = cyc + 1;
            m_clr = '0;
            if (m_valid) begin
                if (ev_ready) begin
                    m_valid   = 1'b0;
                    m_code    = 3'd0;
                    m_free_at = cyc + 1 + COOLDOWN;
                end
            end else if (cyc >= m_free_at && m_pending != 0) begin
                m_pick = -1;
                for (int k = 0; k < 5; k++) begin
                    if (m_pick < 0 && m_pending[k]) m_pick = k;
                end
                m_code        = 3'(m_pick + 1);
                m_clr[m_pick] = 1'b1;
                m_valid       = 1'b1;
            end
            for (int k = 0; k < 5; k++) begin
                if (m_det[k] && m_pending[k] && !m_clr[k] && m_drop < DROP_MAX) m_drop = m_drop + 1;
            end
            m_pending = (m_pending & ~m_clr) | m_det;
            m_det     = m_armed ? (ins ^ m_last) : 5'b0;
            m_last    = ins;
            m_armed   = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_tmp = 1'b1; ins = '0; ev_ready = 1'b0;
        step(); step();
        tests++;
        if ({ev_valid, ev_code, pending, drop_cnt} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_state: got v=%0b c=%0d p=%05b d=%0d, expected all zero", ev_valid, ev_code, pending, drop_cnt);
        end
        reset_tmp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if ({ev_valid, ev_code, pending} !== '0) begin
                fails++;
                $display("[TB] FAIL reset_release_quiet: got v=%0b c=%0d p=%05b, expected all zero", ev_valid, ev_code, pending);
            end
        end
    endtask

    task automatic test_single_event();
        ev_ready = 1'b1;
        ins[2] = ~ins[2];
        for (int k = 0; k < 4; k++) begin
            step();
            tests++;
            if ({ev_valid, ev_code, pending, drop_cnt} !== {m_valid, m_code, m_pending, exp_drop}) begin
                fails++;
                $display("[TB] FAIL single_model: got v=%0b c=%0d p=%05b d=%0d, expected v=%0b c=%0d p=%05b d=%0d", ev_valid, ev_code, pending, drop_cnt, m_valid, m_code, m_pending, exp_drop);
            end
            if (k == 1) begin
                tests++;
                if ({ev_valid, pending} !== {1'b0, 5'b00100}) begin
                    fails++;
                    $display("[TB] FAIL single_pending: got v=%0b p=%05b, expected v=0 p=00100", ev_valid, pending);
                end
            end
            if (k == 2) begin
                tests++;
                if ({ev_valid, ev_code, pending} !== {1'b1, 3'd3, 5'b0}) begin
                    fails++;
                    $display("[TB] FAIL single_offer: got v=%0b c=%0d p=%05b, expected v=1 c=3 p=00000", ev_valid, ev_code, pending);
                end
            end
            if (k == 3) begin
                tests++;
                if ({ev_valid, ev_code} !== {1'b0, 3'd0}) begin
                    fails++;
                    $display("[TB] FAIL single_accept: got v=%0b c=%0d, expected v=0 c=0", ev_valid, ev_code);
                end
            end
        end
        for (int k = 0; k < 10; k++) step();
    endtask

    task automatic test_priority();
        int codes[$];
        int gap = 0;
        ev_ready = 1'b1;
        ins[4] = ~ins[4];
        ins[0] = ~ins[0];
        for (int k = 0; k < 30; k++) begin
            step();
            if (ev_valid) codes.push_back(int'(ev_code));
            else if (codes.size() == 1) gap++;
            tests++;
            if ({ev_valid, ev_code, pending, drop_cnt} !== {m_valid, m_code, m_pending, exp_drop}) begin
                fails++;
                $display("[TB] FAIL priority_model: got v=%0b c=%0d p=%05b d=%0d, expected v=%0b c=%0d p=%05b d=%0d", ev_valid, ev_code, pending, drop_cnt, m_valid, m_code, m_pending, exp_drop);
            end
        end
        tests++;
        if (codes.size() != 2 || codes[0] != 1 || codes[1] != 5) begin
            fails++;
            $display("[TB] FAIL priority_order: got %0d events first=%0d, expected 2 events codes 1 then 5", codes.size(), (codes.size() > 0) ? codes[0] : 0);
        end
        tests++;
        if (gap != COOLDOWN + 1) begin
            fails++;
            $display("[TB] FAIL priority_gap: got %0d low cycles, expected %0d", gap, COOLDOWN + 1);
        end
    endtask

    task automatic test_hold();
        bit found = 0;
        ev_ready = 1'b0;
        ins[0] = ~ins[0];
        step(); step(); step();
        for (int k = 0; k < 10; k++) begin
            if (k == 2) ins[1] = ~ins[1];
            step();
            tests++;
            if ({ev_valid, ev_code} !== {1'b1, 3'd1}) begin
                fails++;
                $display("[TB] FAIL hold_stable: got v=%0b c=%0d, expected v=1 c=1", ev_valid, ev_code);
            end
        end
        tests++;
        if (pending !== 5'b00010) begin
            fails++;
            $display("[TB] FAIL hold_pending: got p=%05b, expected 00010", pending);
        end
        ev_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (ev_valid && ev_code == 3'd2) found = 1;
            tests++;
            if ({ev_valid, ev_code, pending, drop_cnt} !== {m_valid, m_code, m_pending, exp_drop}) begin
                fails++;
                $display("[TB] FAIL hold_model: got v=%0b c=%0d p=%05b d=%0d, expected v=%0b c=%0d p=%05b d=%0d", ev_valid, ev_code, pending, drop_cnt, m_valid, m_code, m_pending, exp_drop);
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL hold_medicina: got no code 2 offer, expected one within 30 cycles");
        end
    endtask

    task automatic test_drop();
        int ult_events = 0;
        logic [DROP_W-1:0] want;
`ifdef DROP_CNT_EN
        want = DROP_W'(2);
`else
        want = '0;
`endif
        ev_ready = 1'b0;
        ins[0] = ~ins[0];
        step(); step(); step();
        for (int k = 0; k < 3; k++) begin
            ins[3] = ~ins[3];
            step();
        end
        step(); step();
        tests++;
        if ({pending[3], drop_cnt} !== {1'b1, want}) begin
            fails++;
            $display("[TB] FAIL drop_count: got p3=%0b d=%0d, expected p3=1 d=%0d", pending[3], drop_cnt, want);
        end
        ev_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (ev_valid && ev_code == 3'd4) ult_events++;
            tests++;
            if ({ev_valid, ev_code, pending, drop_cnt} !== {m_valid, m_code, m_pending, exp_drop}) begin
                fails++;
                $display("[TB] FAIL drop_model: got v=%0b c=%0d p=%05b d=%0d, expected v=%0b c=%0d p=%05b d=%0d", ev_valid, ev_code, pending, drop_cnt, m_valid, m_code, m_pending, exp_drop);
            end
        end
        tests++;
        if (ult_events != 1) begin
            fails++;
            $display("[TB] FAIL drop_single_ult: got %0d ult events, expected 1", ult_events);
        end
    endtask

    task automatic test_back_to_back();
        int test_events = 0;
        ev_ready = 1'b1;
        ins[0] = ~ins[0];
        step();
        ins[0] = ~ins[0];
        step(); step();
        tests++;
        if ({ev_valid, ev_code, pending[0]} !== {1'b1, 3'd1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL b2b_set_wins: got v=%0b c=%0d p0=%0b, expected v=1 c=1 p0=1", ev_valid, ev_code, pending[0]);
        end
        test_events = 1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (ev_valid && ev_code == 3'd1) test_events++;
            tests++;
            if ({ev_valid, ev_code, pending, drop_cnt} !== {m_valid, m_code, m_pending, exp_drop}) begin
                fails++;
                $display("[TB] FAIL b2b_model: got v=%0b c=%0d p=%05b d=%0d, expected v=%0b c=%0d p=%05b d=%0d", ev_valid, ev_code, pending, drop_cnt, m_valid, m_code, m_pending, exp_drop);
            end
        end
        tests++;
        if (test_events != 2) begin
            fails++;
            $display("[TB] FAIL b2b_count: got %0d test events, expected 2", test_events);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(7) == 0) ins[b] = ~ins[b];
            end
            ev_ready = 1'($urandom_range(1));
            step();
            tests++;
            if ({ev_valid, ev_code, pending, drop_cnt} !== {m_valid, m_code, m_pending, exp_drop}) begin
                fails++;
                $display("[TB] FAIL random_model: cycle %0d got v=%0b c=%0d p=%05b d=%0d, expected v=%0b c=%0d p=%05b d=%0d", k, ev_valid, ev_code, pending, drop_cnt, m_valid, m_code, m_pending, exp_drop);
            end
        end
        ev_ready = 1'b1;
        for (int k = 0; k < 40; k++) step();
    endtask

    task automatic test_reset_mid_offer();
        ev_ready = 1'b0;
        ins[2] = ~ins[2];
        step(); step(); step();
        tests++;
        if (ev_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset_offer_up: got v=%0b, expected 1", ev_valid);
        end
        #2 reset_tmp = 1'b1;
        #1;
        tests++;
        if ({ev_valid, ev_code, pending, drop_cnt} !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_clear: got v=%0b c=%0d p=%05b d=%0d, expected all zero", ev_valid, ev_code, pending, drop_cnt);
        end
        ins = 5'b11111;
        step(); step();
        reset_tmp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            tests++;
            if ({ev_valid, pending} !== '0) begin
                fails++;
                $display("[TB] FAIL midreset_spurious: got v=%0b p=%05b, expected v=0 p=00000", ev_valid, pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_priority();
        test_hold();
        test_drop();
        test_back_to_back();
        test_random();
        test_reset_mid_offer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
